cw310_sram_arb: RTL
===================

# cw310_sram_arb

Arbitrating sequencer for the CW310 board's external asynchronous byte-wide SRAM (20-bit address, 8-bit data). Shares the SRAM between two requesters:
- port 0: the USB register path (host read/write through `REG_SRAM_*` registers);
- port 1: the on-FPGA memory test engine enabled by `REG_SRAM_EN`.

It sits between those requesters and the top-level SRAM pins. It generates CE/OE/WE strobes with parameterized pulse widths and returns read data plus a per-port completion pulse.

## Interface
Parameters:
- pADDR_WIDTH, 20, SRAM address width.
- pWR_CYCLES, 2, WEn low-pulse width in clocks (1..15).
- pRD_CYCLES, 2, OEn low time before data sample, in clocks (1..15).

Ports:
- usb_clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_i  in  2  per-port request; held until the matching gnt_o pulse.
- we_i  in  2  per-port write (1) / read (0).
- addr0_i, addr1_i  in  pADDR_WIDTH  per-port address.
- wdata0_i, wdata1_i  in  8  per-port write data.
- gnt_o  out  2  one-cycle accept pulse; at most one bit set.
- done_o  out  2  one-cycle completion pulse for the port owning the transaction.
- rdata_o  out  8  read data, valid in the done_o cycle of a read, held until the next read completes.
- busy_o  out  1  high whenever state is not IDLE.
- sram_a_o  out  pADDR_WIDTH  SRAM address.
- sram_dq_o  out  8  SRAM write data.
- sram_dq_i  in  8  SRAM read data.
- sram_dq_oe_o  out  1  top-level tristate enable for SRAM_DQ.
- sram_cen_o, sram_ce2_o, sram_oen_o, sram_wen_o  out  1 each  SRAM strobes.

## Operation
- Reset values:
  - sram_cen_o=1, sram_ce2_o=0, sram_oen_o=1, sram_wen_o=1;
  - sram_dq_oe_o=0, sram_a_o=0, sram_dq_o=0;
  - gnt_o=0, done_o=0, rdata_o=0, busy_o=0;
  - state=IDLE, last-granted pointer=1.
- States: IDLE, WR_PULSE, WR_HOLD, RD_WAIT, DONE.
- IDLE: if any req_i is high, choose a winner, register gnt_o[winner]=1, and latch we/addr/wdata into internal registers. Go to WR_PULSE or RD_WAIT. Reload the cycle counter with pWR_CYCLES-1 or pRD_CYCLES-1.
- Arbitration: if only one port requests, that port wins. If both request, the port that is not the last-granted port wins (round robin). The pointer updates on every grant.
- WR_PULSE:
  - Drive cen=0, ce2=1, wen=0, dq_oe=1, with address and data from the latched values.
  - Hold for pWR_CYCLES clocks, counting down, then go to WR_HOLD.
- WR_HOLD: one clock with wen=1; cen, ce2, address, dq_oe and data unchanged (data hold). Then go to DONE.
- RD_WAIT:
  - Drive cen=0, ce2=1, oen=0, dq_oe=0.
  - Hold for pRD_CYCLES clocks. On the last one, capture sram_dq_i into rdata_o, then go to DONE.
- DONE:
  - Strobes return to their reset (inactive) values; dq_oe=0.
  - Pulse done_o[owner] for one clock, then return to IDLE.
- The latched address and data cannot change mid-transaction. Requester inputs are ignored outside IDLE.
- A requester that keeps req_i high after gnt_o is treated as a new request at the next IDLE.
- sram_dq_oe_o and sram_oen_o are never both asserted (dq_oe=1 while oen=0 is illegal).

## Timing
- Grant latency: gnt_o is high in the clock after req_i is first sampled high in IDLE. The SRAM strobes assert in that same gnt_o cycle.
- Write: wen is low for exactly pWR_CYCLES clocks, followed by 1 hold clock. done_o arrives pWR_CYCLES+2 clocks after gnt_o.
- Read: oen is low for exactly pRD_CYCLES clocks. done_o arrives pRD_CYCLES+1 clocks after gnt_o, with rdata_o valid.
- Back-to-back throughput: DONE always costs 1 clock, so at least 1 inactive-strobe cycle separates consecutive transactions (bus turnaround).
- busy_o is high from the gnt_o cycle through the DONE cycle inclusive.
- Reset mid-transaction: on the clock after reset is sampled high, all outputs are at their reset values. No done_o is issued for the aborted transaction.
- Reset and req_i both high: reset wins; no grant.

## Configuration
- CW310_SRAM_ARB_FIXED_PRIO_EN:
  - Defined: port 0 (USB) always wins a tie, and the last-granted pointer is not implemented.
  - Undefined: round robin as described above.

## Test plan
- Write port 0, addr 0x00005, data 0xA5, default params:
  - gnt_o=01 one clock after req;
  - wen low 2 clocks with sram_a_o=0x00005, sram_dq_o=0xA5, dq_oe=1;
  - done_o=01 4 clocks after gnt.
- Read port 0, addr 0x00005, using the bench SRAM model:
  - oen low 2 clocks, dq_oe=0 throughout;
  - done_o=01 3 clocks after gnt with rdata_o=0xA5.
- Both ports hold req_i high for 4 transactions:
  - without the macro: grants in order 0,1,0,1;
  - with the macro: grants 0,0,0,0 while req_i[0] stays high.
- Reset asserted during the second WR_PULSE clock: next clock wen=1, cen=1, dq_oe=0, busy_o=0; done_o never pulses.
- Write then read back-to-back to addr 0xFFFFF, data 0x3C:
  - at least one clock with all strobes inactive between the two transactions;
  - oen and dq_oe never both active;
  - read returns 0x3C.
- pWR_CYCLES=1, pRD_CYCLES=1: write done at gnt+3, read done at gnt+2; strobe widths exactly 1 clock.

Source files
------------

// File: rtl/cw310_sram_arb.sv
// ============================================================================
// Module   : cw310_sram_arb
// Function : Two-port arbitrating sequencer for the CW310 async byte-wide SRAM.
//            Define CW310_SRAM_ARB_FIXED_PRIO_EN for fixed port-0 tie priority.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cw310_sram_arb #(
  parameter int pADDR_WIDTH = 20,
  parameter int pWR_CYCLES  = 2,
  parameter int pRD_CYCLES  = 2
) (
  input  logic                   usb_clk,
  input  logic                   reset,
  input  logic [1:0]             req_i,
  input  logic [1:0]             we_i,
  input  logic [pADDR_WIDTH-1:0] addr0_i,
  input  logic [pADDR_WIDTH-1:0] addr1_i,
  input  logic [7:0]             wdata0_i,
  input  logic [7:0]             wdata1_i,
  output logic [1:0]             gnt_o,
  output logic [1:0]             done_o,
  output logic [7:0]             rdata_o,
  output logic                   busy_o,
  output logic [pADDR_WIDTH-1:0] sram_a_o,
  output logic [7:0]             sram_dq_o,
  input  logic [7:0]             sram_dq_i,
  output logic                   sram_dq_oe_o,
  output logic                   sram_cen_o,
  output logic                   sram_ce2_o,
  output logic                   sram_oen_o,
  output logic                   sram_wen_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_PULSE = 3'd1,
    WR_HOLD  = 3'd2,
    RD_WAIT  = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [3:0] c_WR_LOAD = 4'(pWR_CYCLES - 1);
  localparam logic [3:0] c_RD_LOAD = 4'(pRD_CYCLES - 1);

  state_t                 r_state, w_state_nxt;
  logic [3:0]             r_cnt, w_cnt_nxt;
  logic                   r_owner, w_owner_nxt;
  logic                   w_win;
  logic [1:0]             w_gnt_nxt, w_done_nxt;
  logic [7:0]             w_rdata_nxt, w_dq_nxt;
  logic [pADDR_WIDTH-1:0] w_a_nxt;
  logic                   w_cen_nxt, w_ce2_nxt, w_oen_nxt, w_wen_nxt, w_dq_oe_nxt;

`ifdef CW310_SRAM_ARB_FIXED_PRIO_EN
  assign w_win = ~req_i[0];
`else
  logic r_last;

  // On a tie the port that did not win last time is served.
  assign w_win = (&req_i) ? ~r_last : req_i[1];

  always_ff @(posedge usb_clk) begin
    if (reset)
      r_last <= 1'b1;
    else if (r_state == IDLE && |req_i)
      r_last <= w_win;
  end
`endif

  assign busy_o = (r_state != IDLE);

  // All strobes are registered: the values below are those for the next cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_owner_nxt = r_owner;
    w_gnt_nxt   = 2'b00;
    w_done_nxt  = 2'b00;
    w_rdata_nxt = rdata_o;
    w_a_nxt     = sram_a_o;
    w_dq_nxt    = sram_dq_o;
    w_cen_nxt   = 1'b1;
    w_ce2_nxt   = 1'b0;
    w_oen_nxt   = 1'b1;
    w_wen_nxt   = 1'b1;
    w_dq_oe_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (|req_i) begin
          w_gnt_nxt[w_win] = 1'b1;
          w_owner_nxt      = w_win;
          w_a_nxt          = w_win ? addr1_i : addr0_i;
          w_dq_nxt         = w_win ? wdata1_i : wdata0_i;
          w_cen_nxt        = 1'b0;
          w_ce2_nxt        = 1'b1;
          if (we_i[w_win]) begin
            w_state_nxt = WR_PULSE;
            w_cnt_nxt   = c_WR_LOAD;
            w_wen_nxt   = 1'b0;
            w_dq_oe_nxt = 1'b1;
          end else begin
            w_state_nxt = RD_WAIT;
            w_cnt_nxt   = c_RD_LOAD;
            w_oen_nxt   = 1'b0;
          end
        end
      end
      WR_PULSE: begin
        w_cen_nxt   = 1'b0;
        w_ce2_nxt   = 1'b1;
        w_dq_oe_nxt = 1'b1;
        if (r_cnt == 4'd0) begin
          w_state_nxt = WR_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
          w_wen_nxt = 1'b0;
        end
      end
      WR_HOLD: begin
        w_state_nxt = DONE;
      end
      RD_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_rdata_nxt = sram_dq_i;
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
          w_cen_nxt = 1'b0;
          w_ce2_nxt = 1'b1;
          w_oen_nxt = 1'b0;
        end
      end
      DONE: begin
        w_done_nxt[r_owner] = 1'b1;
        w_state_nxt         = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge usb_clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_owner      <= 1'b0;
      gnt_o        <= 2'b00;
      done_o       <= 2'b00;
      rdata_o      <= 8'h00;
      sram_a_o     <= '0;
      sram_dq_o    <= 8'h00;
      sram_dq_oe_o <= 1'b0;
      sram_cen_o   <= 1'b1;
      sram_ce2_o   <= 1'b0;
      sram_oen_o   <= 1'b1;
      sram_wen_o   <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_owner      <= w_owner_nxt;
      gnt_o        <= w_gnt_nxt;
      done_o       <= w_done_nxt;
      rdata_o      <= w_rdata_nxt;
      sram_a_o     <= w_a_nxt;
      sram_dq_o    <= w_dq_nxt;
      sram_dq_oe_o <= w_dq_oe_nxt;
      sram_cen_o   <= w_cen_nxt;
      sram_ce2_o   <= w_ce2_nxt;
      sram_oen_o   <= w_oen_nxt;
      sram_wen_o   <= w_wen_nxt;
    end
  end

endmodule

`default_nettype wire
